// File: rtl/eth_traffic_gen.sv
// Purpose: in-fabric packet source driving the eth_tx application interface (head handshake, payload, look-ahead).
// Latency: start_i -> app_early_v_o next cycle; app_ready_v_i -> first beat next cycle; all outputs registered.
// Backpressure: holds the head request in REQ until app_ready_v_i; no backpressure once beats start.
// Optional feature macro: ETH_TRAFFIC_GEN_LEN_SWEEP_EN (packet length grows by one byte per completed packet).
module eth_traffic_gen #(
  parameter int DATA_W      = 16,
  parameter int KEEP_W      = DATA_W / 8,
  parameter int LEN_W       = $clog2(KEEP_W + 1),
  parameter int PKT_LEN_W   = 16,
  parameter int BLOCK_N     = 8,
  parameter int BLOCK_LEN_W = $clog2(BLOCK_N + 1),
  parameter int MIN_LEN     = 1,
  parameter int MAX_LEN     = 1500,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [PKT_LEN_W-1:0]   cfg_len_i,
  input  logic [CNT_W-1:0]       cfg_count_i,
  input  logic [7:0]             cfg_gap_i,
  output logic                   app_early_v_o,
  input  logic                   app_ready_v_i,
  output logic [PKT_LEN_W-1:0]   app_pkt_len_o,
  output logic [DATA_W-1:0]      app_data_o,
  output logic [LEN_W-1:0]       app_len_o,
  output logic                   app_last_o,
  output logic                   app_last_block_next_o,
  output logic [BLOCK_LEN_W-1:0] app_last_block_next_len_o,
  output logic                   app_cancel_o,
  output logic                   busy_o,
  output logic [CNT_W-1:0]       pkt_cnt_o
);

  localparam logic [PKT_LEN_W-1:0] KEEP_P  = PKT_LEN_W'(KEEP_W);
  localparam logic [PKT_LEN_W-1:0] BLOCK_P = PKT_LEN_W'(BLOCK_N);
  localparam logic [PKT_LEN_W-1:0] MIN_P   = PKT_LEN_W'(MIN_LEN);
  localparam logic [PKT_LEN_W-1:0] MAX_P   = PKT_LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_LAST,
    S_GAP
  } state_t;

  state_t state, state_nxt;

  // run context
  logic [PKT_LEN_W-1:0] beat_q, beat_nxt;     // index of the beat currently on the outputs
  logic [7:0]           gap_cnt_q, gap_cnt_nxt;
  logic [PKT_LEN_W-1:0] len_q;                // effective (clamped) packet length
  logic [CNT_W-1:0]     cnt_lim_q;
  logic [7:0]           gap_q;
  logic [7:0]           seq_q;                // per-packet payload seed S
  logic [CNT_W-1:0]     pkt_cnt_q;

  // derived values
  logic [PKT_LEN_W-1:0] len_clamp;
  logic [PKT_LEN_W-1:0] len_after;
  logic [PKT_LEN_W-1:0] nbeats;
  logic [PKT_LEN_W-1:0] beat_inc;
  logic                 count_hit;

  // FSM control strobes and next output values
  logic                 load_cfg;
  logic                 done;
  logic                 emit;
  logic [PKT_LEN_W-1:0] nb_idx;
  logic                 nb_last;
  logic                 early_nxt;
  logic                 cancel_nxt;
  logic [PKT_LEN_W-1:0] pkt_len_nxt;

  // beat field generator outputs
  logic [PKT_LEN_W-1:0]   bx;
  logic [PKT_LEN_W-1:0]   b_rem;
  logic [DATA_W-1:0]      b_dat;
  logic [LEN_W-1:0]       b_len;
  logic                   b_lbn;
  logic [BLOCK_LEN_W-1:0] b_lbn_len;

  assign nbeats    = len_q / KEEP_P;
  assign beat_inc  = beat_q + PKT_LEN_W'(1);
  assign count_hit = (cnt_lim_q != '0) && ((pkt_cnt_q + CNT_W'(1)) == cnt_lim_q);
  assign pkt_cnt_o = pkt_cnt_q;

  // clamp the requested length into the legal window
  always_comb begin
    len_clamp = cfg_len_i;
    if (cfg_len_i < MIN_P) begin
      len_clamp = MIN_P;
    end else if (cfg_len_i > MAX_P) begin
      len_clamp = MAX_P;
    end
  end

  // length used for the packet after the one completing now
  always_comb begin
`ifdef ETH_TRAFFIC_GEN_LEN_SWEEP_EN
    len_after = (len_q >= MAX_P) ? MIN_P : (len_q + PKT_LEN_W'(1));
`else
    len_after = len_q;
`endif
  end

  // FSM next-state and next-output decisions
  always_comb begin
    state_nxt   = state;
    beat_nxt    = beat_q;
    gap_cnt_nxt = gap_cnt_q;
    load_cfg    = 1'b0;
    done        = 1'b0;
    emit        = 1'b0;
    nb_idx      = '0;
    nb_last     = 1'b0;
    early_nxt   = 1'b0;
    cancel_nxt  = 1'b0;
    pkt_len_nxt = app_pkt_len_o;
    case (state)
      S_IDLE: begin
        // stop wins over a simultaneous start
        if (start_i && !stop_i) begin
          state_nxt   = S_REQ;
          load_cfg    = 1'b1;
          early_nxt   = 1'b1;
          pkt_len_nxt = len_clamp;
        end
      end
      S_REQ: begin
        if (stop_i) begin
          // head not yet accepted, so simply withdraw the request
          state_nxt = S_IDLE;
        end else if (app_ready_v_i) begin
          emit     = 1'b1;
          nb_idx   = '0;
          beat_nxt = '0;
          if (nbeats != '0) begin
            state_nxt = S_DATA;
          end else begin
            state_nxt = S_LAST;
            nb_last   = 1'b1;
          end
        end else begin
          early_nxt = 1'b1;
        end
      end
      S_DATA: begin
        if (stop_i) begin
          state_nxt  = S_IDLE;
          cancel_nxt = 1'b1;
        end else begin
          emit     = 1'b1;
          nb_idx   = beat_inc;
          beat_nxt = beat_inc;
          if (beat_inc == nbeats) begin
            state_nxt = S_LAST;
            nb_last   = 1'b1;
          end
        end
      end
      S_LAST: begin
        if (stop_i) begin
          state_nxt  = S_IDLE;
          cancel_nxt = 1'b1;
        end else begin
          done = 1'b1;
          if (count_hit) begin
            state_nxt = S_IDLE;
          end else if (gap_q != 8'd0) begin
            state_nxt   = S_GAP;
            gap_cnt_nxt = gap_q - 8'd1;
          end else begin
            state_nxt   = S_REQ;
            early_nxt   = 1'b1;
            pkt_len_nxt = len_after;
          end
        end
      end
      S_GAP: begin
        if (stop_i) begin
          state_nxt = S_IDLE;
        end else if (gap_cnt_q == 8'd0) begin
          state_nxt   = S_REQ;
          early_nxt   = 1'b1;
          pkt_len_nxt = len_q;
        end else begin
          gap_cnt_nxt = gap_cnt_q - 8'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // payload, byte count and last-block look-ahead for the beat about to be presented
  always_comb begin
    bx    = nb_idx * KEEP_P;
    b_rem = len_q % KEEP_P;
    b_dat = '0;
    for (int j = 0; j < KEEP_W; j++) begin
      // tail bytes past the valid length of the final beat stay zero
      if (!nb_last || (PKT_LEN_W'(j) < b_rem)) begin
        b_dat[j*8 +: 8] = seq_q + bx[7:0] + 8'(j);
      end
    end
    b_len     = nb_last ? LEN_W'(b_rem) : LEN_W'(KEEP_W);
    b_lbn     = ((bx % BLOCK_P) == '0) && ((bx / BLOCK_P) == (len_q / BLOCK_P));
    b_lbn_len = b_lbn ? BLOCK_LEN_W'(len_q % BLOCK_P) : '0;
  end

  // FSM state register and run context
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      beat_q    <= '0;
      gap_cnt_q <= '0;
      len_q     <= '0;
      cnt_lim_q <= '0;
      gap_q     <= '0;
      seq_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state     <= state_nxt;
      beat_q    <= beat_nxt;
      gap_cnt_q <= gap_cnt_nxt;
      if (load_cfg) begin
        len_q     <= len_clamp;
        cnt_lim_q <= cfg_count_i;
        gap_q     <= cfg_gap_i;
        seq_q     <= '0;
        pkt_cnt_q <= '0;
      end else if (done) begin
        len_q     <= len_after;
        seq_q     <= seq_q + 8'd1;
        pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
      end
    end
  end

  // registered application-side outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      app_early_v_o             <= 1'b0;
      app_pkt_len_o             <= '0;
      app_data_o                <= '0;
      app_len_o                 <= '0;
      app_last_o                <= 1'b0;
      app_last_block_next_o     <= 1'b0;
      app_last_block_next_len_o <= '0;
      app_cancel_o              <= 1'b0;
      busy_o                    <= 1'b0;
    end else begin
      app_early_v_o             <= early_nxt;
      app_pkt_len_o             <= pkt_len_nxt;
      app_data_o                <= emit ? b_dat : '0;
      app_len_o                 <= emit ? b_len : '0;
      app_last_o                <= emit && nb_last;
      app_last_block_next_o     <= emit && b_lbn;
      app_last_block_next_len_o <= emit ? b_lbn_len : '0;
      app_cancel_o              <= cancel_nxt;
      busy_o                    <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_eth_traffic_gen.sv
// Directed bench for eth_traffic_gen with default parameters (DATA_W=16, BLOCK_N=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Each step advances exactly one clock cycle.
module tb_eth_traffic_gen;

  logic        clk;
  logic        nreset;
  logic        start_i;
  logic        stop_i;
  logic [15:0] cfg_len_i;
  logic [31:0] cfg_count_i;
  logic [7:0]  cfg_gap_i;
  logic        app_early_v_o;
  logic        app_ready_v_i;
  logic [15:0] app_pkt_len_o;
  logic [15:0] app_data_o;
  logic [1:0]  app_len_o;
  logic        app_last_o;
  logic        app_last_block_next_o;
  logic [3:0]  app_last_block_next_len_o;
  logic        app_cancel_o;
  logic        busy_o;
  logic [31:0] pkt_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  eth_traffic_gen dut (
    .clk                       (clk),
    .nreset                    (nreset),
    .start_i                   (start_i),
    .stop_i                    (stop_i),
    .cfg_len_i                 (cfg_len_i),
    .cfg_count_i               (cfg_count_i),
    .cfg_gap_i                 (cfg_gap_i),
    .app_early_v_o             (app_early_v_o),
    .app_ready_v_i             (app_ready_v_i),
    .app_pkt_len_o             (app_pkt_len_o),
    .app_data_o                (app_data_o),
    .app_len_o                 (app_len_o),
    .app_last_o                (app_last_o),
    .app_last_block_next_o     (app_last_block_next_o),
    .app_last_block_next_len_o (app_last_block_next_len_o),
    .app_cancel_o              (app_cancel_o),
    .busy_o                    (busy_o),
    .pkt_cnt_o                 (pkt_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [1:14] exp_e;
  logic [1:14] exp_l;

  initial begin
    nreset        = 1'b0;
    start_i       = 1'b0;
    stop_i        = 1'b0;
    cfg_len_i     = 16'd0;
    cfg_count_i   = 32'd0;
    cfg_gap_i     = 8'd0;
    app_ready_v_i = 1'b0;

    // reset state
    #3;
    chk("rst_early",   32'(app_early_v_o), 32'd0);
    chk("rst_busy",    32'(busy_o), 32'd0);
    chk("rst_cnt",     pkt_cnt_o, 32'd0);
    chk("rst_data",    32'(app_data_o), 32'd0);
    chk("rst_len",     32'(app_len_o), 32'd0);
    chk("rst_last",    32'(app_last_o), 32'd0);
    chk("rst_cancel",  32'(app_cancel_o), 32'd0);
    chk("rst_lbn",     32'(app_last_block_next_o), 32'd0);
    chk("rst_pkt_len", 32'(app_pkt_len_o), 32'd0);
    step();
    nreset = 1'b1;
    step();

    // L=5, one packet, ready high
    cfg_len_i = 16'd5; cfg_count_i = 32'd1; cfg_gap_i = 8'd0; app_ready_v_i = 1'b1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("a_req_early", 32'(app_early_v_o), 32'd1);
    chk("a_req_plen",  32'(app_pkt_len_o), 32'd5);
    chk("a_req_busy",  32'(busy_o), 32'd1);
    step();
    chk("a_b0_early",  32'(app_early_v_o), 32'd0);
    chk("a_b0_data",   32'(app_data_o), 32'h0100);
    chk("a_b0_len",    32'(app_len_o), 32'd2);
    chk("a_b0_last",   32'(app_last_o), 32'd0);
    chk("a_b0_lbn",    32'(app_last_block_next_o), 32'd1);
    chk("a_b0_lbnl",   32'(app_last_block_next_len_o), 32'd5);
    step();
    chk("a_b1_data",   32'(app_data_o), 32'h0302);
    chk("a_b1_lbn",    32'(app_last_block_next_o), 32'd0);
    chk("a_b1_lbnl",   32'(app_last_block_next_len_o), 32'd0);
    step();
    chk("a_lst_data",  32'(app_data_o), 32'h0004);
    chk("a_lst_len",   32'(app_len_o), 32'd1);
    chk("a_lst_last",  32'(app_last_o), 32'd1);
    step();
    chk("a_end_cnt",   pkt_cnt_o, 32'd1);
    chk("a_end_busy",  32'(busy_o), 32'd0);
    chk("a_end_last",  32'(app_last_o), 32'd0);

    // L=20: ten full beats, look-ahead only on beat 8, then a zero-length last beat
    cfg_len_i = 16'd20; start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("b_req_plen", 32'(app_pkt_len_o), 32'd20);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("b_b%0d_data", i), 32'(app_data_o), 32'(((2 * i + 1) << 8) | (2 * i)));
      chk($sformatf("b_b%0d_len", i),  32'(app_len_o), 32'd2);
      chk($sformatf("b_b%0d_lbn", i),  32'(app_last_block_next_o), (i == 8) ? 32'd1 : 32'd0);
      chk($sformatf("b_b%0d_lbnl", i), 32'(app_last_block_next_len_o), (i == 8) ? 32'd4 : 32'd0);
    end
    step();
    chk("b_lst_last", 32'(app_last_o), 32'd1);
    chk("b_lst_len",  32'(app_len_o), 32'd0);
    chk("b_lst_data", 32'(app_data_o), 32'd0);
    step();
    chk("b_end_cnt",  pkt_cnt_o, 32'd1);
    chk("b_end_busy", 32'(busy_o), 32'd0);

    // three packets of L=2 with a gap of 2
    cfg_len_i = 16'd2; cfg_count_i = 32'd3; cfg_gap_i = 8'd2; start_i = 1'b1;
    exp_e = 14'b10000100001000;
    exp_l = 14'b00100001000010;
    step();
    start_i = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      chk($sformatf("c_early_%0d", c), 32'(app_early_v_o), 32'(exp_e[c]));
      chk($sformatf("c_last_%0d", c),  32'(app_last_o), 32'(exp_l[c]));
      if (c == 5)  chk("c_gap_busy", 32'(busy_o), 32'd1);
      if (c == 4)  chk("c_gap_cnt1", pkt_cnt_o, 32'd1);
      if (c == 7)  chk("c_p2_data",  32'(app_data_o), 32'h0201);
      if (c == 12) chk("c_p3_data",  32'(app_data_o), 32'h0302);
      if (c == 14) begin
        chk("c_end_busy", 32'(busy_o), 32'd0);
        chk("c_end_cnt",  pkt_cnt_o, 32'd3);
      end
      if (c < 14) step();
    end

    // ready held low for 7 cycles
    cfg_count_i = 32'd1; cfg_gap_i = 8'd0; app_ready_v_i = 1'b0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      chk($sformatf("d_wait_%0d", i), 32'(app_early_v_o), 32'd1);
      step();
    end
    app_ready_v_i = 1'b1;
    chk("d_wait_8",   32'(app_early_v_o), 32'd1);
    step();
    chk("d_b0_early", 32'(app_early_v_o), 32'd0);
    chk("d_b0_data",  32'(app_data_o), 32'h0100);
    chk("d_b0_len",   32'(app_len_o), 32'd2);
    step();
    chk("d_lst_last", 32'(app_last_o), 32'd1);
    step();
    chk("d_end_cnt",  pkt_cnt_o, 32'd1);
    chk("d_end_busy", 32'(busy_o), 32'd0);

    // stop on beat 3 of an L=20 packet
    cfg_len_i = 16'd20; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step(); step(); step(); step();
    chk("e_b3_data", 32'(app_data_o), 32'h0706);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("e_cancel",     32'(app_cancel_o), 32'd1);
    chk("e_cancel_len", 32'(app_len_o), 32'd0);
    chk("e_busy",       32'(busy_o), 32'd0);
    chk("e_cnt",        pkt_cnt_o, 32'd0);
    step();
    chk("e_cancel_off", 32'(app_cancel_o), 32'd0);
    chk("e_idle_busy",  32'(busy_o), 32'd0);

    // simultaneous start and stop in IDLE: stop wins
    start_i = 1'b1; stop_i = 1'b1;
    step();
    start_i = 1'b0; stop_i = 1'b0;
    chk("g_ss_busy",  32'(busy_o), 32'd0);
    chk("g_ss_early", 32'(app_early_v_o), 32'd0);

    // over-long length clamps to MAX_LEN; stop in REQ withdraws the request without cancel
    cfg_len_i = 16'd3000; app_ready_v_i = 1'b0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("g_clamp_max", 32'(app_pkt_len_o), 32'd1500);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("g_rstop_early",  32'(app_early_v_o), 32'd0);
    chk("g_rstop_cancel", 32'(app_cancel_o), 32'd0);
    chk("g_rstop_busy",   32'(busy_o), 32'd0);

    // zero length clamps to MIN_LEN=1: straight to a one-byte last beat
    cfg_len_i = 16'd0; app_ready_v_i = 1'b1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("g_clamp_min", 32'(app_pkt_len_o), 32'd1);
    step();
    chk("g_min_last", 32'(app_last_o), 32'd1);
    chk("g_min_len",  32'(app_len_o), 32'd1);
    chk("g_min_data", 32'(app_data_o), 32'h0000);
    chk("g_min_lbn",  32'(app_last_block_next_o), 32'd1);
    chk("g_min_lbnl", 32'(app_last_block_next_len_o), 32'd1);
    step();
    chk("g_min_cnt",  pkt_cnt_o, 32'd1);

    // asynchronous reset in the middle of DATA
    cfg_len_i = 16'd20; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step(); step(); step();
    chk("f_b2_data", 32'(app_data_o), 32'h0504);
    #2;
    nreset = 1'b0;
    #1;
    chk("f_rst_early", 32'(app_early_v_o), 32'd0);
    chk("f_rst_data",  32'(app_data_o), 32'd0);
    chk("f_rst_len",   32'(app_len_o), 32'd0);
    chk("f_rst_busy",  32'(busy_o), 32'd0);
    chk("f_rst_plen",  32'(app_pkt_len_o), 32'd0);
    chk("f_rst_cnt",   pkt_cnt_o, 32'd0);
    chk("f_rst_cancel", 32'(app_cancel_o), 32'd0);
    #1;
    nreset = 1'b1;
    cfg_len_i = 16'd5; start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("f_re_early", 32'(app_early_v_o), 32'd1);
    step();
    chk("f_re_data",  32'(app_data_o), 32'h0100);
    chk("f_re_cancel", 32'(app_cancel_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
